// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Purpose:
//   Sequences a PLL from reset to a qualified lock and releases the reset of
//   the PLL-clocked core only after the lock indication has been stable for a
//   programmable number of cycles. Lock loss while running restarts the
//   sequence. Repeated lock timeouts end in a sticky FAULT state that only
//   rst can leave.
//
//   Sequence: PLL_RESET -> WAIT_LOCK -> STABLE -> RUN
//             WAIT_LOCK --timeout--> PLL_RESET (or FAULT after MAX_RETRIES)
//             STABLE --lock dropped--> WAIT_LOCK
//             RUN --lock dropped--> PLL_RESET (with a lock_lost pulse)
//
// Parameters:
//   SYNC_STAGES          flops in the pll_locked synchronizer (minimum 2)
//   PLL_RST_CYCLES       cycles pll_rst is held per reset attempt
//   LOCK_STABLE_CYCLES   consecutive locked cycles required before RUN
//   LOCK_TIMEOUT_CYCLES  unlocked cycles waited in WAIT_LOCK before retrying
//   MAX_RETRIES          consecutive timeouts that lead to FAULT (1..15)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock flag, asynchronous to clk
//   pll_rst      out  active-high reset to the PLL
//   core_rst     out  active-high reset for the PLL-clocked core
//   ready        out  high only in RUN (always ~core_rst)
//   lock_lost    out  one-cycle pulse when lock drops in RUN
//   retry_count  out  consecutive lock timeouts since the last RUN (saturates)
//   fault        out  high in FAULT
//   state_dbg    out  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_count,
    output logic       fault,
    output logic [2:0] state_dbg
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    // A single-flop synchronizer is not metastability safe, so the chain is
    // never shorter than two flops whatever the parameter says.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Counter widths hold the full terminal count so nothing can wrap even
    // for parameter values that are exact powers of two.
    localparam int RW = $clog2(PLL_RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST     = RW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_PLL_RESET = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t state;

    // -----------------------------------------------------------------------
    // pll_locked synchronizer
    // -----------------------------------------------------------------------
    // pll_locked enters at bit 0 and is consumed only from the last flop.
    logic [SYNC_N-1:0] sync_chain;
    logic              locked_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_N-2:0], pll_locked};
        end
    end

    assign locked_s = sync_chain[SYNC_N-1];

    // -----------------------------------------------------------------------
    // Counters
    // -----------------------------------------------------------------------
    // rst_cnt     : cycles already spent in PLL_RESET for this attempt
    // timeout_cnt : unlocked cycles spent in WAIT_LOCK for this attempt; it
    //               deliberately survives short STABLE excursions so a lock
    //               that keeps chattering still times out eventually
    // stable_cnt  : consecutive locked_s=1 cycles, including the cycle in
    //               WAIT_LOCK that first saw the lock
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [SW-1:0] stable_cnt;

    // Next retry value, saturating at 15.
    logic [3:0] retry_inc;

    assign retry_inc = (retry_count == 4'd15) ? 4'd15 : (retry_count + 4'd1);

    // -----------------------------------------------------------------------
    // Supervisor FSM with registered outputs
    // -----------------------------------------------------------------------
    // Every transition assigns the outputs that belong to the destination
    // state, so the outputs always describe the state register they sit
    // next to. ready is driven as the complement of core_rst on every path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_PLL_RESET;
            rst_cnt     <= '0;
            timeout_cnt <= '0;
            stable_cnt  <= '0;
            pll_rst     <= 1'b1;
            core_rst    <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 4'd0;
            fault       <= 1'b0;
        end else begin
            // lock_lost is a single-cycle pulse; only the RUN exit raises it.
            lock_lost <= 1'b0;

            case (state)
                // -----------------------------------------------------------
                S_PLL_RESET: begin
                    pll_rst  <= 1'b1;
                    core_rst <= 1'b1;
                    ready    <= 1'b0;
                    if (rst_cnt == RST_LAST) begin
                        // Last cycle of the reset pulse: release the PLL.
                        rst_cnt <= '0;
                        pll_rst <= 1'b0;
                        state   <= S_WAIT_LOCK;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                end

                // -----------------------------------------------------------
                S_WAIT_LOCK: begin
                    pll_rst  <= 1'b0;
                    core_rst <= 1'b1;
                    ready    <= 1'b0;
                    if (locked_s) begin
                        // Checked first: a lock arriving on the same edge
                        // the timeout expires wins, with no retry charged.
                        stable_cnt <= SW'(1);
                        state      <= S_STABLE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        timeout_cnt <= '0;
                        retry_count <= retry_inc;
                        pll_rst     <= 1'b1;
                        if (retry_inc >= RETRY_LIMIT) begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end else begin
                            rst_cnt <= '0;
                            state   <= S_PLL_RESET;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end

                // -----------------------------------------------------------
                S_STABLE: begin
                    pll_rst  <= 1'b0;
                    core_rst <= 1'b1;
                    ready    <= 1'b0;
                    if (locked_s) begin
                        if (stable_cnt >= STABLE_LAST) begin
                            // Qualified lock: release the core. The retry
                            // history and the timeout budget start afresh.
                            stable_cnt  <= '0;
                            timeout_cnt <= '0;
                            retry_count <= 4'd0;
                            core_rst    <= 1'b0;
                            ready       <= 1'b1;
                            state       <= S_RUN;
                        end else begin
                            stable_cnt <= stable_cnt + SW'(1);
                        end
                    end else begin
                        // A glitchy lock is not a timeout: no retry charged,
                        // and the timeout counter keeps its progress.
                        stable_cnt <= '0;
                        state      <= S_WAIT_LOCK;
                    end
                end

                // -----------------------------------------------------------
                S_RUN: begin
                    if (!locked_s) begin
                        lock_lost <= 1'b1;
                        pll_rst   <= 1'b1;
                        core_rst  <= 1'b1;
                        ready     <= 1'b0;
                        rst_cnt   <= '0;
                        state     <= S_PLL_RESET;
                    end else begin
                        pll_rst  <= 1'b0;
                        core_rst <= 1'b0;
                        ready    <= 1'b1;
                    end
                end

                // -----------------------------------------------------------
                S_FAULT: begin
                    // Sticky until rst; retry_count keeps the final count.
                    pll_rst  <= 1'b1;
                    core_rst <= 1'b1;
                    ready    <= 1'b0;
                    fault    <= 1'b1;
                end

                // -----------------------------------------------------------
                default: begin
                    // Unreachable encodings restart the sequence cleanly.
                    rst_cnt     <= '0;
                    timeout_cnt <= '0;
                    stable_cnt  <= '0;
                    pll_rst     <= 1'b1;
                    core_rst    <= 1'b1;
                    ready       <= 1'b0;
                    fault       <= 1'b0;
                    state       <= S_PLL_RESET;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
//
// Bench for pll_lock_supervisor with small parameters. Directed vectors from
// a table cover bring-up and a lock drop in RUN; hand-written sequences cover
// the multi-cycle corners; a long random phase is checked against a
// behavioural model that tracks the supervisor as named phases and elapsed
// cycle counts.
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

    localparam int SYNC_STAGES         = 2;
    localparam int PLL_RST_CYCLES      = 4;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int MAX_RETRIES         = 2;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;
    logic       fault;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES        (SYNC_STAGES),
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .MAX_RETRIES        (MAX_RETRIES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .core_rst   (core_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count),
        .fault      (fault),
        .state_dbg  (state_dbg)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected outputs packed as {pll_rst, core_rst, ready, lock_lost, fault, retry_count}
    logic [8:0] exp_q[$];

    function automatic logic [8:0] pk(input logic p, input logic c, input logic r,
                                      input logic l, input logic f, input logic [3:0] n);
        return {p, c, r, l, f, n};
    endfunction

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    // The PLL lock is seen SYNC_STAGES edges late; the model keeps the raw
    // samples in a queue and acts on the oldest one.
    localparam int PH_RESETTING = 0;
    localparam int PH_WAITING   = 1;
    localparam int PH_QUALIFY   = 2;
    localparam int PH_RUNNING   = 3;
    localparam int PH_FAULTED   = 4;

    int  m_phase;
    int  m_reset_elapsed;
    int  m_unlocked_elapsed;
    int  m_locked_run;
    int  m_retries;
    bit  m_lost;
    bit  m_seen[$];

    task automatic model_step(input logic r, input logic pl);
        bit ls;
        m_lost = 1'b0;
        if (r) begin
            m_phase = PH_RESETTING;
            m_reset_elapsed = 0;
            m_unlocked_elapsed = 0;
            m_locked_run = 0;
            m_retries = 0;
            m_seen.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_seen.push_back(1'b0);
        end else begin
            ls = m_seen.pop_front();
            m_seen.push_back(pl);
            case (m_phase)
                PH_RESETTING: begin
                    m_reset_elapsed++;
                    if (m_reset_elapsed == PLL_RST_CYCLES) begin
                        m_reset_elapsed = 0;
                        m_phase = PH_WAITING;
                    end
                end
                PH_WAITING: begin
                    if (ls) begin
                        m_locked_run = 1;
                        m_phase = PH_QUALIFY;
                    end else begin
                        m_unlocked_elapsed++;
                        if (m_unlocked_elapsed == LOCK_TIMEOUT_CYCLES) begin
                            m_unlocked_elapsed = 0;
                            m_retries = (m_retries >= 15) ? 15 : m_retries + 1;
                            m_phase = (m_retries >= MAX_RETRIES) ? PH_FAULTED : PH_RESETTING;
                        end
                    end
                end
                PH_QUALIFY: begin
                    if (ls) begin
                        m_locked_run++;
                        if (m_locked_run >= LOCK_STABLE_CYCLES) begin
                            m_locked_run = 0;
                            m_unlocked_elapsed = 0;
                            m_retries = 0;
                            m_phase = PH_RUNNING;
                        end
                    end else begin
                        m_locked_run = 0;
                        m_phase = PH_WAITING;
                    end
                end
                PH_RUNNING: begin
                    if (!ls) begin
                        m_lost = 1'b1;
                        m_reset_elapsed = 0;
                        m_phase = PH_RESETTING;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [8:0] model_outputs();
        return pk(m_phase == PH_RESETTING || m_phase == PH_FAULTED,
                  m_phase != PH_RUNNING,
                  m_phase == PH_RUNNING,
                  m_lost,
                  m_phase == PH_FAULTED,
                  4'(m_retries));
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard checks
    // ------------------------------------------------------------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_nib(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs(input logic [8:0] e, input string tag);
        check_bit({tag, ".pll_rst"},   pll_rst,   e[8]);
        check_bit({tag, ".core_rst"},  core_rst,  e[7]);
        check_bit({tag, ".ready"},     ready,     e[6]);
        check_bit({tag, ".lock_lost"}, lock_lost, e[5]);
        check_bit({tag, ".fault"},     fault,     e[4]);
        check_nib({tag, ".retry"},     retry_count, e[3:0]);
    endtask

    // ------------------------------------------------------------------
    // Driver: called at a falling edge, applies inputs for one rising edge
    // and checks the DUT against the model at the next falling edge.
    // ------------------------------------------------------------------
    task automatic step(input logic r, input logic pl, input string tag);
        logic [8:0] e;
        rst = r;
        pll_locked = pl;
        model_step(r, pl);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        compare_outputs(e, tag);
    endtask

    task automatic bound_check(input string name, input bit ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s: condition not reached within cycle budget", name);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       r;
        logic       pl;
        logic [8:0] exp;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        bit   found;
        logic lvl;
        int   lvl_left;

        // Bring-up with lock held, then a one-cycle lock drop in RUN.
        tbl[0] = '{1'b1, 1'b1, pk(1, 1, 0, 0, 0, 4'd0)};        // in reset
        for (int i = 1; i <= 3; i++)
            tbl[i] = '{1'b0, 1'b1, pk(1, 1, 0, 0, 0, 4'd0)};    // pll_rst pulse
        for (int i = 4; i <= 11; i++)
            tbl[i] = '{1'b0, 1'b1, pk(0, 1, 0, 0, 0, 4'd0)};    // wait / qualify
        tbl[12] = '{1'b0, 1'b1, pk(0, 0, 1, 0, 0, 4'd0)};       // 8th locked sample
        tbl[13] = '{1'b0, 1'b1, pk(0, 0, 1, 0, 0, 4'd0)};
        tbl[14] = '{1'b0, 1'b1, pk(0, 0, 1, 0, 0, 4'd0)};
        tbl[15] = '{1'b0, 1'b0, pk(0, 0, 1, 0, 0, 4'd0)};       // lock drops 1 cycle
        tbl[16] = '{1'b0, 1'b1, pk(0, 0, 1, 0, 0, 4'd0)};
        tbl[17] = '{1'b0, 1'b1, pk(1, 1, 0, 1, 0, 4'd0)};       // lock_lost pulse
        for (int i = 18; i <= 20; i++)
            tbl[i] = '{1'b0, 1'b1, pk(1, 1, 0, 0, 0, 4'd0)};
        tbl[21] = '{1'b0, 1'b1, pk(0, 1, 0, 0, 0, 4'd0)};       // PLL released

        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].r;
            pll_locked = tbl[i].pl;
            model_step(tbl[i].r, tbl[i].pl);
            @(posedge clk);
            @(negedge clk);
            compare_outputs(tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Re-lock after the drop.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, "relock");
        check_bit("relock.ready_high", ready, 1'b1);
        check_bit("relock.core_rst_low", core_rst, 1'b0);

        // Lock glitch of 3 cycles during STABLE: back to waiting, no retry.
        step(1'b1, 1'b0, "glitch.rst");
        for (int i = 0; i < PLL_RST_CYCLES + 2; i++) step(1'b0, 1'b0, "glitch.pre");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "glitch.high");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "glitch.low");
        check_bit("glitch.core_rst", core_rst, 1'b1);
        check_bit("glitch.pll_rst", pll_rst, 1'b0);
        check_nib("glitch.retry", retry_count, 4'd0);

        // Lock never arrives: one retry, then FAULT.
        step(1'b1, 1'b0, "nolock.rst");
        for (int i = 0; i < PLL_RST_CYCLES + LOCK_TIMEOUT_CYCLES; i++)
            step(1'b0, 1'b0, "nolock.first");
        check_nib("nolock.retry1", retry_count, 4'd1);
        check_bit("nolock.pll_rst_retry", pll_rst, 1'b1);
        for (int i = 0; i < PLL_RST_CYCLES + LOCK_TIMEOUT_CYCLES; i++)
            step(1'b0, 1'b0, "nolock.second");
        check_bit("nolock.fault", fault, 1'b1);
        check_bit("nolock.fault_pll_rst", pll_rst, 1'b1);
        check_nib("nolock.retry2", retry_count, 4'd2);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, "fault.hold");
        check_bit("fault.sticky", fault, 1'b1);
        check_bit("fault.core_rst", core_rst, 1'b1);
        step(1'b1, 1'b1, "fault.rst");
        check_bit("fault.cleared", fault, 1'b0);
        check_nib("fault.retry_cleared", retry_count, 4'd0);

        // One-cycle rst while in RUN restarts the full sequence.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "runrst.up");
        check_bit("runrst.ready_before", ready, 1'b1);
        step(1'b1, 1'b1, "runrst.pulse");
        check_bit("runrst.pll_rst", pll_rst, 1'b1);
        check_bit("runrst.core_rst", core_rst, 1'b1);
        check_bit("runrst.ready", ready, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "runrst.again");
        check_bit("runrst.ready_after", ready, 1'b1);

        // Lock seen on the very edge the timeout would fire, with one retry
        // already charged so a timeout would have meant FAULT.
        step(1'b1, 1'b0, "race.rst");
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 1'b0, "race.wait");
            if (m_phase == PH_WAITING && m_retries == 1 &&
                m_unlocked_elapsed == LOCK_TIMEOUT_CYCLES - 1 - SYNC_STAGES)
                found = 1'b1;
        end
        bound_check("race.setup", found);
        for (int i = 0; i < SYNC_STAGES + 1; i++) step(1'b0, 1'b1, "race.lock");
        check_bit("race.no_fault", fault, 1'b0);
        check_bit("race.pll_rst", pll_rst, 1'b0);
        check_nib("race.retry_kept", retry_count, 4'd1);
        for (int i = 0; i < LOCK_STABLE_CYCLES + 2; i++) step(1'b0, 1'b1, "race.run");
        check_bit("race.ready", ready, 1'b1);
        check_nib("race.retry_cleared", retry_count, 4'd0);

        // Random lock behaviour with occasional resets.
        lvl = 1'b1;
        lvl_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (lvl_left == 0) begin
                lvl = ($urandom_range(0, 3) != 0);
                lvl_left = lvl ? $urandom_range(1, 60) : $urandom_range(1, 50);
            end
            lvl_left--;
            step(($urandom_range(0, 299) == 0), lvl, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Whole-run guard against a stalled simulation.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
